pixel_streamer: RTL and testbench

- Upstream feeder for the classifier top level.
- Accepts 8-bit grayscale pixels one per handshake from a byte source (UART receiver / test DMA) and stores one full image in an internal frame buffer.
- Converts each byte to fixed-point and announces the image with a one-cycle image_ready pulse.
- Then presents INPUT_SIZE pixels per cycle in order, and holds off the next image until the classifier reports label_ready.

---
 rtl/pixel_streamer_if.sv | 33 +++
 rtl/pixel_streamer.sv | 163 ++++++++++++++++
 tb/tb_pixel_streamer.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_streamer_if.sv
// rtl/pixel_streamer_if.sv - byte-in / pixel-beat-out handshake bundle for pixel_streamer
//
// Ports carried:
//   in_valid    source -> streamer  byte source has a pixel on in_data
//   in_data     source -> streamer  unsigned 8-bit pixel intensity
//   in_ready    streamer -> source  streamer accepts in_data this cycle
//   image_ready streamer -> sink    one-cycle pulse, streaming starts next cycle
//   pixels      streamer -> sink    current beat, element i = pixel beat*INPUT_SIZE+i
//   label_ready sink -> streamer    classifier finished with the current image
//   busy        streamer -> sink    an image is held
// master: the byte source / classifier side. slave: the streamer itself.
interface pixel_streamer_if #(
  parameter int INPUT_SIZE  = 1,
  parameter int FIXED_WIDTH = 16
);
  logic                                   in_valid;
  logic [7:0]                             in_data;
  logic                                   in_ready;
  logic                                   image_ready;
  logic [INPUT_SIZE-1:0][FIXED_WIDTH-1:0] pixels;
  logic                                   label_ready;
  logic                                   busy;

  modport master (
    output in_valid, in_data, label_ready,
    input  in_ready, image_ready, pixels, busy
  );

  modport slave (
    input  in_valid, in_data, label_ready,
    output in_ready, image_ready, pixels, busy
  );
endinterface

// File: rtl/pixel_streamer.sv
// rtl/pixel_streamer.sv - buffers one grayscale image and streams it as fixed-point beats
//
// Ports:
//   clock  rising-edge system clock
//   reset  asynchronous, active-low
//   bus    pixel_streamer_if.slave (in_valid/in_data/in_ready byte input,
//          image_ready/pixels/busy beat output, label_ready release input)
// Flow: FILL collects NUM_PIXELS bytes, ANNOUNCE pulses image_ready, STREAM
// presents one registered beat per cycle, WAIT_LABEL holds until label_ready.
module pixel_streamer #(
  parameter int NUM_PIXELS    = 784,
  parameter int INPUT_SIZE    = 1,
  parameter int FIXED_WIDTH   = 16,
  parameter int FRACTION_BITS = 8
) (
  input  logic            clock,
  input  logic            reset,
  pixel_streamer_if.slave bus
);

  localparam int NUM_BEATS = (NUM_PIXELS + INPUT_SIZE - 1) / INPUT_SIZE;
  localparam int PTR_W     = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
  localparam int BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  // Byte b means b/256, so it sits FRACTION_BITS-8 places above the LSB.
  localparam int SHIFT     = FRACTION_BITS - 8;

  localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(NUM_PIXELS - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);

  typedef enum logic [1:0] {
    FILL       = 2'd0,
    ANNOUNCE   = 2'd1,
    STREAM     = 2'd2,
    WAIT_LABEL = 2'd3
  } state_t;

  state_t state, state_next;

  logic [PTR_W-1:0]                       wr_ptr;
  logic [BEAT_W-1:0]                      beat_cnt;
  logic [BEAT_W-1:0]                      beat_sel;
  logic [FIXED_WIDTH-1:0]                 frame_buf [NUM_PIXELS];
  logic [INPUT_SIZE-1:0][FIXED_WIDTH-1:0] pix_q;
  logic [INPUT_SIZE-1:0][FIXED_WIDTH-1:0] beat_data;
  logic [FIXED_WIDTH-1:0]                 in_word;

  logic wr_en;
  logic load_beat;
  logic clear_pix;
  logic in_ready_c;
  logic image_ready_c;
  logic busy_c;

  assign in_word = {{(FIXED_WIDTH-8){1'b0}}, bus.in_data} << SHIFT;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  // Next state and control strobes. beat_sel names the beat that will be
  // visible on pixels during the following cycle.
  always_comb begin
    state_next    = state;
    in_ready_c    = 1'b0;
    image_ready_c = 1'b0;
    busy_c        = 1'b1;
    wr_en         = 1'b0;
    load_beat     = 1'b0;
    clear_pix     = 1'b0;
    beat_sel      = '0;

    case (state)
      FILL: begin
        in_ready_c = 1'b1;
        busy_c     = 1'b0;
        if (bus.in_valid) begin
          wr_en = 1'b1;
          if (wr_ptr == LAST_PTR) begin
            state_next = ANNOUNCE;
          end
        end
      end

      ANNOUNCE: begin
        image_ready_c = 1'b1;
        load_beat     = 1'b1;
        beat_sel      = '0;
        state_next    = STREAM;
      end

      STREAM: begin
        if (beat_cnt == LAST_BEAT) begin
          clear_pix  = 1'b1;
          state_next = WAIT_LABEL;
        end else begin
          load_beat = 1'b1;
          beat_sel  = beat_cnt + 1'b1;
        end
      end

      WAIT_LABEL: begin
        if (bus.label_ready) begin
          state_next = FILL;
        end
      end

      default: begin
        state_next = FILL;
      end
    endcase
  end

  // Gather the selected beat from the frame buffer; slots past the end of
  // the image (last beat when NUM_PIXELS % INPUT_SIZE != 0) read as zero.
  always_comb begin
    int idx;
    idx       = 0;
    beat_data = '0;
    for (int i = 0; i < INPUT_SIZE; i++) begin
      idx = int'(beat_sel) * INPUT_SIZE + i;
      if (idx < NUM_PIXELS) begin
        beat_data[i] = frame_buf[PTR_W'(idx)];
      end
    end
  end

  // Write pointer, beat counter and registered pixel output
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      beat_cnt <= '0;
      pix_q    <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (load_beat) begin
        beat_cnt <= beat_sel;
        pix_q    <= beat_data;
      end else if (clear_pix) begin
        pix_q <= '0;
      end
    end
  end

  // Frame buffer storage is deliberately not reset.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      frame_buf[wr_ptr] <= in_word;
    end
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.image_ready = image_ready_c;
  assign bus.busy        = busy_c;
  assign bus.pixels      = pix_q;

endmodule

// File: tb/tb_pixel_streamer.sv
// tb/tb_pixel_streamer.sv - self-checking bench for pixel_streamer (8x2 and 5x2 configurations)
module tb_pixel_streamer;

  localparam int NPA  = 8;
  localparam int ISA  = 2;
  localparam int NBA  = 4;
  localparam int NPB  = 5;
  localparam int ISB  = 2;
  localparam int NBB  = 3;
  localparam int FW   = 16;
  localparam int FRAC = 8;

  logic clock = 1'b0;
  logic rst_n_a;
  logic rst_n_b;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  pixel_streamer_if #(.INPUT_SIZE(ISA), .FIXED_WIDTH(FW)) ba ();
  pixel_streamer_if #(.INPUT_SIZE(ISB), .FIXED_WIDTH(FW)) bb ();

  pixel_streamer #(
    .NUM_PIXELS(NPA), .INPUT_SIZE(ISA), .FIXED_WIDTH(FW), .FRACTION_BITS(FRAC)
  ) dut_a (
    .clock (clock),
    .reset (rst_n_a),
    .bus   (ba.slave)
  );

  pixel_streamer #(
    .NUM_PIXELS(NPB), .INPUT_SIZE(ISB), .FIXED_WIDTH(FW), .FRACTION_BITS(FRAC)
  ) dut_b (
    .clock (clock),
    .reset (rst_n_b),
    .bus   (bb.slave)
  );

  typedef logic [7:0]  bytes_a_t [NPA];
  typedef logic [15:0] words_a_t [NPA];

  typedef struct {
    logic [7:0]  in_byte;
    logic [15:0] exp_word;
  } vec_t;

  vec_t table_v [16];

  logic        s_rdy;
  logic        s_img;
  logic        s_busy;
  logic [63:0] s_pix;

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_word(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference conversion: intensity b represents b/256, expressed with FRAC fraction bits.
  function automatic logic [15:0] to_fixed(input logic [7:0] b);
    return 16'((int'(b) * (1 << FRAC)) / 256);
  endfunction

  // Reference beat: pixels b*ISA .. b*ISA+ISA-1, zero beyond the image.
  function automatic logic [63:0] beat_a(input words_a_t w, input int b);
    logic [63:0] r;
    int p;
    r = '0;
    for (int i = 0; i < ISA; i++) begin
      p = b * ISA + i;
      if (p < NPA) r[i*FW +: FW] = w[p];
    end
    return r;
  endfunction

  // Drive inputs for one cycle (called just after a rising edge), sample mid-cycle.
  task automatic cyc_a(input logic v, input logic [7:0] d, input logic lr);
    ba.in_valid    = v;
    ba.in_data     = d;
    ba.label_ready = lr;
    @(negedge clock);
    s_rdy  = ba.in_ready;
    s_img  = ba.image_ready;
    s_busy = ba.busy;
    s_pix  = 64'(ba.pixels);
    @(posedge clock);
    #1;
  endtask

  task automatic cyc_b(input logic v, input logic [7:0] d, input logic lr);
    bb.in_valid    = v;
    bb.in_data     = d;
    bb.label_ready = lr;
    @(negedge clock);
    s_rdy  = bb.in_ready;
    s_img  = bb.image_ready;
    s_busy = bb.busy;
    s_pix  = 64'(bb.pixels);
    @(posedge clock);
    #1;
  endtask

  // One full image through DUT A: fill (optionally gapped), announce,
  // NBA beats, a WAIT_LABEL hold, then the releasing label_ready cycle.
  task automatic run_image_a(input bytes_a_t bytes, input words_a_t exp_w,
                             input int gap_pct, input bit early_lr, input int hold,
                             input bit hold_valid, input logic [7:0] hold_data);
    int   k;
    int   guard;
    logic v;
    logic lr;
    k     = 0;
    guard = 0;
    while (k < NPA && guard < 200) begin
      v  = (int'($urandom_range(99)) >= gap_pct);
      lr = early_lr ? 1'($urandom_range(1)) : 1'b0;
      cyc_a(v, bytes[k], lr);
      check_bit("fill in_ready", s_rdy, 1'b1);
      check_bit("fill image_ready", s_img, 1'b0);
      check_bit("fill busy", s_busy, 1'b0);
      check_word("fill pixels", s_pix, 64'd0);
      if (v && s_rdy) k++;
      guard++;
    end
    if (k < NPA) check_word("fill transfer count", 64'(k), 64'(NPA));

    cyc_a(hold_valid, hold_data, early_lr);
    check_bit("announce image_ready", s_img, 1'b1);
    check_bit("announce in_ready", s_rdy, 1'b0);
    check_bit("announce busy", s_busy, 1'b1);
    check_word("announce pixels", s_pix, 64'd0);

    for (int b = 0; b < NBA; b++) begin
      cyc_a(hold_valid, hold_data, early_lr);
      check_word($sformatf("beat %0d pixels", b), s_pix, beat_a(exp_w, b));
      check_bit("stream image_ready", s_img, 1'b0);
      check_bit("stream in_ready", s_rdy, 1'b0);
      check_bit("stream busy", s_busy, 1'b1);
    end

    for (int h = 0; h < hold; h++) begin
      cyc_a(hold_valid, hold_data, 1'b0);
      check_word("wait pixels", s_pix, 64'd0);
      check_bit("wait in_ready", s_rdy, 1'b0);
      check_bit("wait busy", s_busy, 1'b1);
      check_bit("wait image_ready", s_img, 1'b0);
    end

    cyc_a(hold_valid, hold_data, 1'b1);
    check_word("release pixels", s_pix, 64'd0);
    check_bit("release in_ready", s_rdy, 1'b0);
    check_bit("release busy", s_busy, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bytes_a_t bytes;
    words_a_t words;

    table_v[0]  = '{8'd0,   16'h0000};
    table_v[1]  = '{8'd32,  16'h0020};
    table_v[2]  = '{8'd64,  16'h0040};
    table_v[3]  = '{8'd96,  16'h0060};
    table_v[4]  = '{8'd128, 16'h0080};
    table_v[5]  = '{8'd160, 16'h00A0};
    table_v[6]  = '{8'd192, 16'h00C0};
    table_v[7]  = '{8'd224, 16'h00E0};
    table_v[8]  = '{8'd255, 16'h00FF};
    table_v[9]  = '{8'd1,   16'h0001};
    table_v[10] = '{8'h7F,  16'h007F};
    table_v[11] = '{8'h80,  16'h0080};
    table_v[12] = '{8'h10,  16'h0010};
    table_v[13] = '{8'hAA,  16'h00AA};
    table_v[14] = '{8'h55,  16'h0055};
    table_v[15] = '{8'hFE,  16'h00FE};

    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    ba.in_valid = 1'b0; ba.in_data = 8'd0; ba.label_ready = 1'b0;
    bb.in_valid = 1'b0; bb.in_data = 8'd0; bb.label_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;

    check_bit("reset a in_ready", ba.in_ready, 1'b1);
    check_bit("reset a image_ready", ba.image_ready, 1'b0);
    check_bit("reset a busy", ba.busy, 1'b0);
    check_word("reset a pixels", 64'(ba.pixels), 64'd0);
    check_bit("reset b in_ready", bb.in_ready, 1'b1);
    check_word("reset b pixels", 64'(bb.pixels), 64'd0);
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;
    @(posedge clock);
    #1;

    // Table-driven: two images, back-to-back source, expected words from the table.
    for (int img = 0; img < 2; img++) begin
      for (int j = 0; j < NPA; j++) begin
        bytes[j] = table_v[img*NPA + j].in_byte;
        words[j] = table_v[img*NPA + j].exp_word;
      end
      run_image_a(bytes, words, 0, 1'b0, 2, 1'b0, 8'd0);
    end

    // Backpressure: byte 0x77 held valid from image-full until release.
    for (int j = 0; j < NPA; j++) begin
      bytes[j] = 8'(j * 17 + 3);
      words[j] = to_fixed(bytes[j]);
    end
    run_image_a(bytes, words, 0, 1'b0, 5, 1'b1, 8'h77);
    bytes[0] = 8'h77;
    for (int j = 1; j < NPA; j++) bytes[j] = 8'(200 - j);
    for (int j = 0; j < NPA; j++) words[j] = to_fixed(bytes[j]);
    run_image_a(bytes, words, 0, 1'b0, 1, 1'b0, 8'd0);

    // Early label_ready during fill/announce/stream must not release.
    for (int j = 0; j < NPA; j++) begin
      bytes[j] = 8'($urandom_range(255));
      words[j] = to_fixed(bytes[j]);
    end
    run_image_a(bytes, words, 30, 1'b1, 3, 1'b0, 8'd0);

    // Reset mid-stream, during beat 2.
    for (int j = 0; j < NPA; j++) begin
      bytes[j] = 8'(j + 1);
      words[j] = to_fixed(bytes[j]);
    end
    for (int j = 0; j < NPA; j++) cyc_a(1'b1, bytes[j], 1'b0);
    cyc_a(1'b0, 8'd0, 1'b0);
    cyc_a(1'b0, 8'd0, 1'b0);
    cyc_a(1'b0, 8'd0, 1'b0);
    #1;
    check_word("pre-reset beat 2", 64'(ba.pixels), beat_a(words, 2));
    rst_n_a = 1'b0;
    #1;
    check_word("mid-reset pixels", 64'(ba.pixels), 64'd0);
    check_bit("mid-reset image_ready", ba.image_ready, 1'b0);
    check_bit("mid-reset in_ready", ba.in_ready, 1'b1);
    check_bit("mid-reset busy", ba.busy, 1'b0);
    @(posedge clock);
    #1;
    rst_n_a = 1'b1;
    for (int j = 0; j < NPA; j++) begin
      bytes[j] = 8'(240 - 16 * j);
      words[j] = to_fixed(bytes[j]);
    end
    run_image_a(bytes, words, 0, 1'b0, 0, 1'b0, 8'd0);

    // Randomized images: gapped source, random holds and early labels.
    for (int r = 0; r < 6; r++) begin
      for (int j = 0; j < NPA; j++) begin
        bytes[j] = 8'($urandom_range(255));
        words[j] = to_fixed(bytes[j]);
      end
      run_image_a(bytes, words, 50, 1'($urandom_range(1)), int'($urandom_range(4)),
                  1'($urandom_range(1)), 8'($urandom_range(255)));
    end

    // Padding on the 5-pixel, 2-wide instance: beats {1,2},{3,4},{5,0}.
    for (int j = 0; j < NPB; j++) begin
      cyc_b(1'b1, 8'(j + 1), 1'b0);
      check_bit("pad fill in_ready", s_rdy, 1'b1);
      check_bit("pad fill image_ready", s_img, 1'b0);
    end
    cyc_b(1'b0, 8'd0, 1'b0);
    check_bit("pad announce", s_img, 1'b1);
    cyc_b(1'b0, 8'd0, 1'b0);
    check_word("pad beat 0", s_pix, 64'h0000_0000_0002_0001);
    cyc_b(1'b0, 8'd0, 1'b0);
    check_word("pad beat 1", s_pix, 64'h0000_0000_0004_0003);
    cyc_b(1'b0, 8'd0, 1'b0);
    check_word("pad beat 2", s_pix, 64'h0000_0000_0000_0005);
    cyc_b(1'b0, 8'd0, 1'b0);
    check_word("pad after last beat", s_pix, 64'd0);
    check_bit("pad wait busy", s_busy, 1'b1);
    check_bit("pad wait in_ready", s_rdy, 1'b0);
    cyc_b(1'b0, 8'd0, 1'b1);
    cyc_b(1'b0, 8'd0, 1'b0);
    check_bit("pad released in_ready", s_rdy, 1'b1);
    check_bit("pad released busy", s_busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
